// File: rtl/spi_word_receiver.sv
// SPI mode-0 target oversampled in the fabric clock: deserialises WIDTH-bit words
// into data/valid and shifts a reply word out on sdo, several words per frame.
module spi_word_receiver #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs_n,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             sdo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_reg, sdi_sync_reg, cs_sync_reg;
  logic sck_d_reg, sdi_d_reg, cs_d_reg;
  logic sck_rise_reg, sck_fall_reg, cs_rise_reg, cs_fall_reg;

  state_t           state_reg;
  logic [WIDTH-2:0] rx_reg;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             skip_fall_reg;

  // Synchronisers, then one delayed level per input; events are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_reg <= '0;
      sdi_sync_reg <= '0;
      cs_sync_reg  <= '0;
      sck_d_reg    <= 1'b0;
      sdi_d_reg    <= 1'b0;
      cs_d_reg     <= 1'b0;
      sck_rise_reg <= 1'b0;
      sck_fall_reg <= 1'b0;
      cs_rise_reg  <= 1'b0;
      cs_fall_reg  <= 1'b0;
    end else begin
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
      cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      sck_d_reg    <= sck_sync_reg[SYNC_STAGES-1];
      sdi_d_reg    <= sdi_sync_reg[SYNC_STAGES-1];
      cs_d_reg     <= cs_sync_reg[SYNC_STAGES-1];
      sck_rise_reg <= sck_sync_reg[SYNC_STAGES-1] & ~sck_d_reg;
      sck_fall_reg <= ~sck_sync_reg[SYNC_STAGES-1] & sck_d_reg;
      cs_rise_reg  <= cs_sync_reg[SYNC_STAGES-1] & ~cs_d_reg;
      cs_fall_reg  <= ~cs_sync_reg[SYNC_STAGES-1] & cs_d_reg;
    end
  end

  assign rx_next = {rx_reg, sdi_d_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RESYNC;
      rx_reg        <= '0;
      tx_reg        <= '0;
      cnt_reg       <= '0;
      skip_fall_reg <= 1'b0;
      data          <= '0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        RESYNC: begin
          busy <= 1'b0;
          if (cs_d_reg) state_reg <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          if (cs_fall_reg) begin
            tx_reg        <= tx_data;
            cnt_reg       <= '0;
            skip_fall_reg <= 1'b0;
            state_reg     <= SHIFT;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          if (sck_rise_reg) begin
            rx_reg <= rx_next[WIDTH-2:0];
            if (cnt_reg == LAST_BIT) begin
              data    <= rx_next;
              valid   <= 1'b1;
              cnt_reg <= '0;
              tx_reg  <= tx_data;
              // The fall right after a reload must not shift, or the new MSB is lost.
              skip_fall_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else if (sck_fall_reg && !cs_rise_reg) begin
            if (skip_fall_reg) skip_fall_reg <= 1'b0;
            else               tx_reg <= {tx_reg[WIDTH-2:0], 1'b0};
          end
          if (cs_rise_reg) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            frame_err <= sck_rise_reg ? (cnt_reg != LAST_BIT) : (cnt_reg != '0);
          end
        end
        default: begin
          state_reg <= RESYNC;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sdo = (state_reg == SHIFT) & tx_reg[WIDTH-1];

endmodule
